// File: rtl/ifu_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch_pkg
// Description : Shared constants and helpers for the instruction prefetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_prefetch_pkg;

    localparam logic [31:0] c_INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] c_ZERO_WORD   = 32'h0000_0000;
    localparam logic [31:0] c_RESET_ADDR  = 32'h0000_0000;
    localparam int          c_FIFO_WIDTH  = 64;

    localparam logic [0:0]  c_IFU_S_RESET = 1'b0;
    localparam logic [0:0]  c_IFU_S_RUN   = 1'b1;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fifo
// Description : Generic synchronous FIFO; flush has priority over push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & (r_count != '0);
    assign w_do_push = i_push & ((r_count != c_FULL) | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (c_AW + 1)'(w_do_push) - (c_AW + 1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch
// Description : Sequential instruction fetch with prefetch buffer and jump flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = c_RESET_ADDR,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int              c_CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CW:0]   c_DEPTH = (c_CW + 1)'(FIFO_DEPTH);

    logic [0:0]              r_state;
    logic [0:0]              w_state_next;
    logic [31:0]             r_pc;
    logic [31:0]             r_resp_addr;
    logic [c_CW-1:0]         r_outstanding;
    logic [c_CW-1:0]         r_drop_cnt;
    logic [c_CW-1:0]         w_outstanding_kept;
    logic [c_CW-1:0]         w_fifo_count;
    logic [c_CW:0]           w_credit_used;
    logic [c_FIFO_WIDTH-1:0] w_fifo_head;
    logic [31:0]             w_jump_target;
    logic                    w_run;
    logic                    w_grant;
    logic                    w_rsp;
    logic                    w_push;
    logic                    w_pop;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IFU_S_RESET;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IFU_S_RESET: w_state_next = c_IFU_S_RUN;
            c_IFU_S_RUN:   w_state_next = c_IFU_S_RUN;
        endcase
    end

    assign w_run         = (r_state == c_IFU_S_RUN);
    assign w_jump_target = word_align(jump_addr_i);
    assign inst_valid_o  = (w_fifo_count != '0);
    assign w_pop         = inst_valid_o & ~hold_i & ~jump_flag_i;

    // The slot freed by this cycle's pop is already usable: any word granted
    // now returns no earlier than next cycle, which keeps 1 instr/cycle at depth 2.
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count}
                         - (c_CW + 1)'(w_pop);
    assign bus_req_o     = w_run & ~jump_flag_i & (w_credit_used < c_DEPTH);
    assign bus_addr_o    = r_pc;
    assign w_grant       = bus_req_o & bus_gnt_i;

    // A response with nothing outstanding is a bus protocol error and is ignored.
    assign w_rsp              = bus_rvalid_i & (r_outstanding != '0);
    assign w_push             = w_rsp & (r_drop_cnt == '0) & ~jump_flag_i;
    assign w_outstanding_kept = r_outstanding - r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_ADDR;
            r_resp_addr   <= RESET_ADDR;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_CW'(w_grant) - c_CW'(w_rsp);
            if (jump_flag_i) begin
                r_pc        <= w_jump_target;
                r_resp_addr <= w_jump_target;
                r_drop_cnt  <= r_drop_cnt + w_outstanding_kept - c_CW'(w_rsp);
            end else begin
                if (w_grant) r_pc <= r_pc + 32'd4;
                if (w_push)  r_resp_addr <= r_resp_addr + 32'd4;
                if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    ifu_fifo #(
        .WIDTH (c_FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (jump_flag_i),
        .i_data  ({r_resp_addr, bus_rdata_i}),
        .o_count (w_fifo_count),
        .o_head  (w_fifo_head)
    );

    assign inst_o      = inst_valid_o ? w_fifo_head[31:0]  : c_INST_NOP;
    assign inst_addr_o = inst_valid_o ? w_fifo_head[63:32] : c_ZERO_WORD;

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_prefetch
// Description : Directed self-checking bench for ifu_prefetch with a latency-
//               configurable in-order bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_prefetch;

    localparam logic [31:0] c_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_jump_flag;
    logic [31:0] r_jump_addr;
    logic        r_hold;
    logic        r_gnt;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        w_bus_req;
    logic [31:0] w_bus_addr;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cyc   = 0;
    int lat      = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;
    rsp_t q[$];

    always #5 clk = ~clk;

    ifu_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (r_jump_flag),
        .jump_addr_i  (r_jump_addr),
        .hold_i       (r_hold),
        .bus_req_o    (w_bus_req),
        .bus_addr_o   (w_bus_addr),
        .bus_gnt_i    (r_gnt),
        .bus_rvalid_i (r_rvalid),
        .bus_rdata_i  (r_rdata),
        .inst_valid_o (w_inst_valid),
        .inst_o       (w_inst),
        .inst_addr_o  (w_inst_addr)
    );

    // In-order responder: word granted in cycle N returns in cycle N+lat.
    initial begin
        r_rvalid = 1'b0;
        r_rdata  = '0;
        forever begin
            @(posedge clk);
            tb_cyc++;
            #1;
            if (rst) begin
                q.delete();
                r_rvalid = 1'b0;
            end else if (q.size() > 0 && q[0].due <= tb_cyc) begin
                r_rvalid = 1'b1;
                r_rdata  = q[0].addr ^ c_KEY;
            end else begin
                r_rvalid = 1'b0;
            end
            @(negedge clk);
            if (r_rvalid) q.delete(0);
            if (w_bus_req && r_gnt) q.push_back('{w_bus_addr, tb_cyc + lat});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle, drive inputs, and settle before checks.
    task automatic next(input logic jf, input logic [31:0] ja, input logic hold, input logic gnt);
        @(posedge clk);
        #1;
        r_jump_flag = jf;
        r_jump_addr = ja;
        r_hold      = hold;
        r_gnt       = gnt;
        #1;
    endtask

    // Leaves the bench in cycle 0 (first cycle with rst low).
    task automatic do_reset(input int lat_v, input logic gnt);
        @(posedge clk);
        #1;
        rst = 1'b1;
        r_gnt = 1'b0;
        r_jump_flag = 1'b0;
        r_hold = 1'b0;
        repeat (3) next(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat = lat_v;
        r_gnt = gnt;
        #1;
    endtask

    task automatic check_inst(input string tag, input logic [31:0] addr);
        check_eq({tag, "_valid"}, {31'b0, w_inst_valid}, 32'd1);
        check_eq({tag, "_addr"}, w_inst_addr, addr);
        check_eq({tag, "_data"}, w_inst, addr ^ c_KEY);
    endtask

    initial begin
        rst = 1'b1;
        r_jump_flag = 1'b0;
        r_jump_addr = '0;
        r_hold = 1'b0;
        r_gnt = 1'b0;
        repeat (3) next(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("rst_req", {31'b0, w_bus_req}, 32'd0);
        check_eq("rst_addr", w_bus_addr, 32'h0);
        check_eq("rst_valid", {31'b0, w_inst_valid}, 32'd0);
        check_eq("rst_inst", w_inst, 32'h0000_0013);
        check_eq("rst_iaddr", w_inst_addr, 32'h0);

        // Sequential fetch, then a 5-cycle stall with head at 0x8.
        do_reset(1, 1'b1);
        check_eq("seq_c0_req", {31'b0, w_bus_req}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            next(1'b0, 32'h0, 1'b0, 1'b1);
            check_eq($sformatf("seq_c%0d_req", k), {31'b0, w_bus_req}, 32'd1);
            check_eq($sformatf("seq_c%0d_baddr", k), w_bus_addr, 32'(4 * (k - 1)));
            if (k >= 3) check_inst($sformatf("seq_c%0d", k), 32'(4 * (k - 3)));
            else check_eq($sformatf("seq_c%0d_valid", k), {31'b0, w_inst_valid}, 32'd0);
        end
        for (int k = 5; k <= 9; k++) begin
            next(1'b0, 32'h0, 1'b1, 1'b1);
            check_eq($sformatf("hold_c%0d_req", k), {31'b0, w_bus_req}, 32'd0);
            check_inst($sformatf("hold_c%0d", k), 32'h8);
        end
        for (int k = 10; k <= 13; k++) begin
            next(1'b0, 32'h0, 1'b0, 1'b1);
            check_eq($sformatf("rel_c%0d_req", k), {31'b0, w_bus_req}, 32'd1);
            check_eq($sformatf("rel_c%0d_baddr", k), w_bus_addr, 32'(32'h10 + 4 * (k - 10)));
            check_inst($sformatf("rel_c%0d", k), 32'(32'h8 + 4 * (k - 10)));
        end

        // Jump with two words in flight on a 3-cycle bus.
        do_reset(3, 1'b1);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        next(1'b1, 32'h100, 1'b0, 1'b1);
        check_eq("jmp_c3_req", {31'b0, w_bus_req}, 32'd0);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("jmp_c4_req", {31'b0, w_bus_req}, 32'd0);
        check_eq("jmp_c4_valid", {31'b0, w_inst_valid}, 32'd0);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("jmp_c5_req", {31'b0, w_bus_req}, 32'd1);
        check_eq("jmp_c5_baddr", w_bus_addr, 32'h100);
        for (int k = 5; k <= 8; k++) begin
            if (k > 5) next(1'b0, 32'h0, 1'b0, 1'b1);
            check_eq($sformatf("jmp_c%0d_valid", k), {31'b0, w_inst_valid}, 32'd0);
        end
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_inst("jmp_c9", 32'h100);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_inst("jmp_c10", 32'h104);

        // Jump in the same cycle as a returning word, misaligned target.
        do_reset(1, 1'b1);
        repeat (3) next(1'b0, 32'h0, 1'b0, 1'b1);
        next(1'b1, 32'h203, 1'b0, 1'b1);
        check_eq("jrv_c4_req", {31'b0, w_bus_req}, 32'd0);
        check_inst("jrv_c4", 32'h4);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("jrv_c5_valid", {31'b0, w_inst_valid}, 32'd0);
        check_eq("jrv_c5_req", {31'b0, w_bus_req}, 32'd1);
        check_eq("jrv_c5_baddr", w_bus_addr, 32'h200);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("jrv_c6_valid", {31'b0, w_inst_valid}, 32'd0);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_inst("jrv_c7", 32'h200);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_inst("jrv_c8", 32'h204);

        // Slow grant: request held stable, pc advances only on grant.
        do_reset(1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next(1'b0, 32'h0, 1'b0, 1'b0);
            check_eq($sformatf("sg_c%0d_req", k), {31'b0, w_bus_req}, 32'd1);
            check_eq($sformatf("sg_c%0d_baddr", k), w_bus_addr, 32'h0);
        end
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("sg_c5_baddr", w_bus_addr, 32'h0);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("sg_c6_baddr", w_bus_addr, 32'h4);
        check_eq("sg_c6_valid", {31'b0, w_inst_valid}, 32'd0);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_inst("sg_c7", 32'h0);

        // Address wrap across 2^32.
        do_reset(1, 1'b1);
        next(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        check_eq("wr_c1_req", {31'b0, w_bus_req}, 32'd0);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("wr_c2_baddr", w_bus_addr, 32'hFFFF_FFF8);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("wr_c3_baddr", w_bus_addr, 32'hFFFF_FFFC);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("wr_c4_baddr", w_bus_addr, 32'h0);
        check_inst("wr_c4", 32'hFFFF_FFF8);
        check_eq("wr_c4_rawdata", w_inst, 32'h5A5A_FFF8);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_inst("wr_c5", 32'hFFFF_FFFC);
        next(1'b0, 32'h0, 1'b0, 1'b1);
        check_inst("wr_c6", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
